// File: rtl/cache_arb_pkg.sv
// Shared types and sizes for the cache-to-adaptor arbiter and its grant selector.
package cache_arb_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    RECOVER = 2'd3
  } arb_state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } grant_e;

endpackage

// File: rtl/arb_grant_sel.sv
// Two-requester tie-break: round-robin against the last grant, or fixed D priority.
// Kept free of state so the same selector can serve other two-port arbiters.
module arb_grant_sel
  import cache_arb_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic   i_req,
  input  logic   d_req,
  input  grant_e last_grant,
  output grant_e grant,
  output logic   valid
);

  // Pick a winner among the active requests; a tie depends on the policy.
  always_comb begin
    grant = DCACHE;
    valid = 1'b0;
    if (i_req && d_req) begin
      valid = 1'b1;
      if (RR) begin
        grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
      end else begin
        grant = DCACHE;
      end
    end else if (d_req) begin
      valid = 1'b1;
      grant = DCACHE;
    end else if (i_req) begin
      valid = 1'b1;
      grant = ICACHE;
    end else begin
      valid = 1'b0;
      grant = DCACHE;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Multiplexes the I-cache and D-cache line ports onto the single adaptor port.
// One transaction in flight; request fields are latched at grant and the
// completion is steered back as a one-cycle pulse. A RECOVER state waits out
// a long-held adaptor resp so the just-served request is never re-issued.
module cache_arbiter #(
  parameter bit RR     = 1'b1,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  import cache_arb_pkg::*;

  arb_state_e state_r;
  grant_e     last_grant_r;
  grant_e     grant_s;
  logic       grant_valid_s;
  logic       d_req_s;

  // A D-cache request is either op; read+write together is served as a write.
  assign d_req_s = d_read | d_write;

  arb_grant_sel #(
    .RR(RR)
  ) u_grant_sel (
    .i_req      (i_read),
    .d_req      (d_req_s),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .valid      (grant_valid_s)
  );

  // Sequencer: grant in IDLE, hold the latched request while busy, then wait
  // in RECOVER until the adaptor releases resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= ICACHE;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= {ADDR_W{1'b0}};
      mem_wdata    <= {LINE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            last_grant_r <= grant_s;
            if (grant_s == DCACHE) begin
              state_r     <= D_BUSY;
              mem_address <= d_address;
              mem_write   <= d_write;
              mem_read    <= ~d_write;
              if (d_write) begin
                mem_wdata <= d_wdata;
              end
            end else begin
              state_r     <= I_BUSY;
              mem_address <= i_address;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            state_r   <= RECOVER;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        RECOVER: begin
          if (!mem_resp) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion pulse only while busy, so a resp still high in RECOVER is not repeated.
  assign i_resp = mem_resp & (state_r == I_BUSY);
  assign d_resp = mem_resp & (state_r == D_BUSY);

  // Line data is passed straight through; it is meaningful only in the resp cycle.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected issues and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } iss_t;

  typedef struct {
    logic          is_d;
    logic [LW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] i_address, d_address;
  logic          i_read, d_read, d_write;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_resp, d_resp, mem_read, mem_write, mem_resp;
  logic [AW-1:0] mem_address;

  logic [LW-1:0] i_rdata0, d_rdata0, mem_wdata0;
  logic          i_resp0, d_resp0, mem_read0, mem_write0;
  logic [AW-1:0] mem_address0;

  cache_arbiter #(.RR(1'b1), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Fixed-priority instance runs in lockstep on the same inputs and adaptor resp.
  cache_arbiter #(.RR(1'b0), .LINE_W(LW), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata0), .i_resp(i_resp0),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata0), .d_resp(d_resp0),
    .mem_address(mem_address0), .mem_read(mem_read0), .mem_write(mem_write0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  iss_t exp_iss[$];
  rsp_t exp_rsp[$];

  function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic push_iss(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    iss_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata;
    exp_iss.push_back(e);
  endtask

  task automatic push_rsp(input logic is_d, input logic [LW-1:0] data);
    rsp_t e;
    e.is_d = is_d; e.data = data;
    exp_rsp.push_back(e);
  endtask

  // Adaptor model: resp rises ad_lat cycles after an issue and stays ad_hold cycles.
  int            ad_lat  = 1;
  int            ad_hold = 1;
  logic [LW-1:0] ad_rdata = '0;
  initial begin
    int  cnt;
    int  hold_cnt;
    logic busy;
    cnt = 0; hold_cnt = 0; busy = 1'b0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 1'b0; hold_cnt = 0; mem_resp = 1'b0;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) mem_resp = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          busy = 1'b0; mem_resp = 1'b1; mem_rdata = ad_rdata; hold_cnt = ad_hold;
        end
      end else if (mem_read || mem_write) begin
        busy = 1'b1; cnt = ad_lat;
      end
    end
  end

  // Monitor: compares every issue, hold, drop and resp against the queues.
  logic prev_act = 1'b0, prev_rsp = 1'b0, prev_act0 = 1'b0, chk_rr0 = 1'b0;
  int   rr0_issues = 0;
  iss_t cur;
  always @(negedge clk) begin : mon
    logic act, act0;
    rsp_t r;
    act  = mem_read | mem_write;
    act0 = mem_read0 | mem_write0;
    if (act && !prev_act) begin
      if (exp_iss.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_issue: got issue at addr %0h, required none", mem_address);
      end else begin
        cur = exp_iss.pop_front();
        check("issue_op", {mem_write, mem_read}, cur.wr ? 2'b10 : 2'b01);
        check("issue_addr", mem_address, cur.addr);
        if (cur.wr) check("issue_wdata", mem_wdata, cur.wdata);
      end
    end else if (act) begin
      check("hold_op", {mem_write, mem_read}, cur.wr ? 2'b10 : 2'b01);
      check("hold_addr", mem_address, cur.addr);
      if (cur.wr) check("hold_wdata", mem_wdata, cur.wdata);
    end
    if (prev_rsp && act) begin
      n_tests++; n_fail++;
      $display("FAIL drop_after_resp: got op %b after resp, required 00", {mem_write, mem_read});
    end
    if (i_resp || d_resp) begin
      if (exp_rsp.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp: got i/d %b, required none", {i_resp, d_resp});
      end else begin
        r = exp_rsp.pop_front();
        check("resp_sel", {d_resp, i_resp}, r.is_d ? 2'b10 : 2'b01);
        check("resp_rdata", r.is_d ? d_rdata : i_rdata, r.data);
      end
    end
    if (chk_rr0 && act0 && !prev_act0) begin
      rr0_issues++;
      check("rr0_addr", mem_address0, 32'h0000_8000);
      check("rr0_op", {mem_write0, mem_read0}, 2'b01);
      check("rr0_wdata", mem_wdata0, {LW{1'b0}});
    end
    if (chk_rr0 && (i_resp0 || d_resp0)) begin
      check("rr0_resp_sel", {d_resp0, i_resp0}, 2'b10);
      check("rr0_rdata", d_rdata0, ad_rdata);
      check("rr0_irdata", i_rdata0, ad_rdata);
    end
    prev_act  = act;
    prev_act0 = act0;
    prev_rsp  = i_resp | d_resp;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (exp_iss.size() != 0 || exp_rsp.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d issues and %0d resps outstanding, required 0",
               name, exp_iss.size(), exp_rsp.size());
      exp_iss.delete();
      exp_rsp.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_read"}, mem_read, 1'b0);
    check({tag, "_mem_write"}, mem_write, 1'b0);
    check({tag, "_mem_address"}, mem_address, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, {LW{1'b0}});
    check({tag, "_resp"}, {i_resp, d_resp}, 2'b00);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_address = '0; d_address = '0; d_wdata = '0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // I-cache read with 6-cycle adaptor latency.
    ad_lat = 6; ad_hold = 1; ad_rdata = {32{8'hA5}};
    push_iss(1'b0, 32'h0000_1000, {LW{1'b0}});
    push_rsp(1'b0, {32{8'hA5}});
    i_address = 32'h0000_1000; i_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("issue_latency", mem_read, 1'b1);
    wait_done("iread", 40);
    i_read = 1'b0;
    repeat (3) tick();

    // D-cache write.
    ad_lat = 3; ad_hold = 1; ad_rdata = {8{32'hDEAD_BEEF}};
    push_iss(1'b1, 32'h0000_2040, {4{64'h0123_4567_89AB_CDEF}});
    push_rsp(1'b1, {8{32'hDEAD_BEEF}});
    d_address = 32'h0000_2040; d_wdata = {4{64'h0123_4567_89AB_CDEF}}; d_write = 1'b1;
    wait_done("dwrite", 40);
    d_write = 1'b0;
    repeat (3) tick();

    // Long resp: d_read stays high through the whole resp window.
    ad_lat = 2; ad_hold = 3; ad_rdata = {16{16'h1357}};
    push_iss(1'b0, 32'h0000_3000, {LW{1'b0}});
    push_rsp(1'b1, {16{16'h1357}});
    d_address = 32'h0000_3000; d_read = 1'b1;
    wait_done("longresp", 40);
    n = 0;
    while (mem_resp && n < 20) begin
      tick();
      n++;
    end
    check("longresp_release", mem_resp, 1'b0);
    d_read = 1'b0;
    repeat (3) tick();

    // Reset during D_BUSY, then a normal I read.
    ad_lat = 10; ad_hold = 1;
    push_iss(1'b1, 32'h0000_4000, {8{32'h2468_ACE0}});
    d_address = 32'h0000_4000; d_wdata = {8{32'h2468_ACE0}}; d_write = 1'b1;
    wait_done("midrst_issue", 10);
    repeat (2) tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    d_write = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    ad_lat = 2; ad_hold = 1; ad_rdata = {8{32'h0F1E_2D3C}};
    push_iss(1'b0, 32'h0000_5000, {LW{1'b0}});
    push_rsp(1'b0, {8{32'h0F1E_2D3C}});
    i_address = 32'h0000_5000; i_read = 1'b1;
    wait_done("postrst", 40);
    i_read = 1'b0;
    repeat (3) tick();

    // Illegal read+write served as a write.
    ad_lat = 2; ad_hold = 1; ad_rdata = {16{16'h5A3C}};
    push_iss(1'b1, 32'h0000_6000, {LW{1'b1}});
    push_rsp(1'b1, {16{16'h5A3C}});
    d_address = 32'h0000_6000; d_wdata = {LW{1'b1}}; d_read = 1'b1; d_write = 1'b1;
    wait_done("illegal", 40);
    d_read = 1'b0; d_write = 1'b0;
    repeat (3) tick();

    // Both caches requesting from reset: RR alternates D,I,D,I; fixed priority is always D.
    rst = 1'b1;
    tick();
    ad_lat = 3; ad_hold = 1; ad_rdata = {8{32'hC0DE_0001}};
    i_address = 32'h0000_7000; d_address = 32'h0000_8000;
    i_read = 1'b1; d_read = 1'b1;
    push_iss(1'b0, 32'h0000_8000, {LW{1'b0}}); push_rsp(1'b1, {8{32'hC0DE_0001}});
    push_iss(1'b0, 32'h0000_7000, {LW{1'b0}}); push_rsp(1'b0, {8{32'hC0DE_0001}});
    push_iss(1'b0, 32'h0000_8000, {LW{1'b0}}); push_rsp(1'b1, {8{32'hC0DE_0001}});
    push_iss(1'b0, 32'h0000_7000, {LW{1'b0}}); push_rsp(1'b0, {8{32'hC0DE_0001}});
    chk_rr0 = 1'b1;
    tick();
    rst = 1'b0;
    wait_done("tie", 120);
    i_read = 1'b0; d_read = 1'b0;
    repeat (4) tick();
    chk_rr0 = 1'b0;
    check("rr0_issue_count", rr0_issues, 4);

    check("leftover_issues", exp_iss.size(), 0);
    check("leftover_resps", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
